uart_rx_param: RTL and testbench

//  Parametrised RS-232 receiver; successor to the fixed 8N1 receiver used by the miner host link.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Parity and FSM encodings plus the baud-tick increment calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rxState_t;

   // Rounded fractional increment: one accumulator carry per oversample tick.
   function automatic longint calcInc(
      input longint clkFreq,
      input longint baud,
      input longint os,
      input int     accWidth
   );
      return (baud * os * (longint'(1) << accWidth) + clkFreq / 2)
             / clkFreq;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO for received words.
// Pointers carry a wrap bit so full and empty need no extra counter.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wrData,
   input  logic             pop,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]});
   assign doPop  = pop & ~empty;
   // A pop frees the slot being written, so a full FIFO still accepts.
   assign doPush = push & (~full | doPop);
   assign rdData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised RS-232 receiver: vote, parity/frame flags, break, line-gap eop.
// Define UART_RX_FIFO_EN to buffer words in a FIFO instead of one register.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 80_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int GAP_BITS   = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_overrun,
   output logic                 rx_break,
   output logic                 rx_idle,
   output logic                 rx_eop
);

   if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0 ||
       DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || GAP_BITS < 1 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : gBadParam
      $error("uart_rx_param: illegal parameter combination");
   end

   localparam longint INC_L = calcInc(longint'(CLK_FREQ), longint'(BAUD),
                                      longint'(OVERSAMPLE), ACC_WIDTH);
   localparam logic [ACC_WIDTH:0] INC = INC_L[ACC_WIDTH:0];

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int GW = $clog2(GAP_BITS * OVERSAMPLE + 1);

   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_M0   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_M2   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic [GW-1:0] G_PRE  = GW'(GAP_BITS * OVERSAMPLE - 1);
   localparam parity_t       PAR    = parity_t'(PARITY[1:0]);

   logic [ACC_WIDTH:0]   acc;
   logic                 tick;
   logic                 sync1;
   logic                 rxS;
   rxState_t             state;
   logic [SW-1:0]        sampleCnt;
   logic [SW-1:0]        nextCnt;
   logic                 v0;
   logic                 v1;
   logic                 vote;
   logic                 decide;
   logic [BW-1:0]        bitCnt;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 parBit;
   logic                 parErr;
   logic                 stop2;
   logic                 frameSeen;
   logic                 push;
   logic [DATA_BITS-1:0] pushData;
   logic                 pushPar;
   logic                 pushFrm;
   logic [GW-1:0]        gapCnt;

   assign tick    = acc[ACC_WIDTH];
   assign nextCnt = (sampleCnt == S_LAST) ? '0 : sampleCnt + 1'b1;
   assign vote    = (v0 & v1) | (v0 & rxS) | (v1 & rxS);
   assign decide  = tick && (nextCnt == S_M2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         sync1 <= 1'b1;
         rxS   <= 1'b1;
      end else begin
         acc   <= {1'b0, acc[ACC_WIDTH-1:0]} + INC;
         sync1 <= rxd;
         rxS   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sampleCnt <= '0;
         v0        <= 1'b1;
         v1        <= 1'b1;
         bitCnt    <= '0;
         shiftReg  <= '0;
         parBit    <= 1'b0;
         parErr    <= 1'b0;
         stop2     <= 1'b0;
         frameSeen <= 1'b0;
         push      <= 1'b0;
         pushData  <= '0;
         pushPar   <= 1'b0;
         pushFrm   <= 1'b0;
         rx_break  <= 1'b0;
      end else begin
         push     <= 1'b0;
         rx_break <= 1'b0;
         if (tick) begin
            sampleCnt <= nextCnt;
            if (nextCnt == S_M0) v0 <= rxS;
            if (nextCnt == S_M1) v1 <= rxS;
         end
         unique case (state)
            ST_IDLE: begin
               if (tick && !rxS) begin
                  state     <= ST_START;
                  sampleCnt <= '0;
               end
            end
            ST_START: begin
               if (decide) begin
                  if (vote) begin
                     state <= ST_IDLE;
                  end else begin
                     state     <= ST_DATA;
                     bitCnt    <= '0;
                     parBit    <= 1'b0;
                     parErr    <= 1'b0;
                     stop2     <= 1'b0;
                     frameSeen <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (decide) begin
                  shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
                  bitCnt   <= bitCnt + 1'b1;
                  if (bitCnt == B_LAST)
                     state <= (PAR == PAR_NONE) ? ST_STOP : ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (decide) begin
                  parBit <= vote;
                  parErr <= ^{shiftReg, vote, PAR == PAR_ODD};
                  state  <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (decide) begin
                  if (!vote && !stop2 && shiftReg == '0 && !parBit) begin
                     state    <= ST_BREAK;
                     rx_break <= 1'b1;
                  end else if (vote && !stop2 && STOP_BITS == 2) begin
                     stop2 <= 1'b1;
                  end else begin
                     push     <= 1'b1;
                     pushData <= shiftReg;
                     pushPar  <= parErr;
                     pushFrm  <= ~vote;
                     state    <= ST_IDLE;
                  end
               end
            end
            ST_BREAK: begin
               if (tick && rxS) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gapCnt  <= '0;
         rx_idle <= 1'b0;
         rx_eop  <= 1'b0;
      end else begin
         rx_eop <= 1'b0;
         if (state != ST_IDLE) begin
            gapCnt  <= '0;
            rx_idle <= 1'b0;
         end else if (tick && !rx_idle) begin
            gapCnt <= gapCnt + 1'b1;
            if (gapCnt == G_PRE) begin
               rx_idle <= 1'b1;
               rx_eop  <= frameSeen;
            end
         end
      end
   end

`ifdef UART_RX_FIFO_EN
   logic [DATA_BITS+1:0] fifoOut;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic                 pop;

   assign pop      = rx_valid & rx_ready;
   assign rx_valid = ~fifoEmpty;
   assign {rx_frame_err, rx_parity_err, rx_data} = fifoEmpty ? '0 : fifoOut;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .wrData ({pushFrm, pushPar, pushData}),
      .pop    (pop),
      .rdData (fifoOut),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_overrun <= 1'b0;
      else        rx_overrun <= push & fifoFull & ~pop;
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (push && (!rx_valid || rx_ready)) begin
            rx_valid      <= 1'b1;
            rx_data       <= pushData;
            rx_parity_err <= pushPar;
            rx_frame_err  <= pushFrm;
         end else begin
            if (push)     rx_overrun <= 1'b1;
            if (rx_ready) rx_valid   <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1 and 8E1 instances, directed frames.
module tb_uart_rx_param;

   localparam int CLK_FREQ = 3_686_400;
   localparam int BAUD     = 115_200;
   localparam int BITCLK   = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       rxdA = 1'b1;
   logic       readyA = 1'b1;
   logic [7:0] dataA;
   logic       parErrA, frmErrA, validA, overrunA, breakA, idleA, eopA;

   logic       rxdP = 1'b1;
   logic       readyP = 1'b1;
   logic [7:0] dataP;
   logic       parErrP, frmErrP, validP, overrunP, breakP, idleP, eopP;

   always #5 clk = ~clk;

   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dutA (
      .clk(clk), .rst_n(rst_n), .rxd(rxdA),
      .rx_data(dataA), .rx_parity_err(parErrA), .rx_frame_err(frmErrA),
      .rx_valid(validA), .rx_ready(readyA), .rx_overrun(overrunA),
      .rx_break(breakA), .rx_idle(idleA), .rx_eop(eopA)
   );

   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(1)) dutP (
      .clk(clk), .rst_n(rst_n), .rxd(rxdP),
      .rx_data(dataP), .rx_parity_err(parErrP), .rx_frame_err(frmErrP),
      .rx_valid(validP), .rx_ready(readyP), .rx_overrun(overrunP),
      .rx_break(breakP), .rx_idle(idleP), .rx_eop(eopP)
   );

   int nChecks = 0;
   int nFails  = 0;
   logic [9:0] qA[$];
   logic [9:0] qP[$];
   int wordsA = 0, ovCntA = 0, brkCntA = 0, eopCntA = 0;
   int wordsP = 0, ovCntP = 0, brkCntP = 0, eopCntP = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (validA && readyA) begin
            wordsA++;
            if (qA.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL wordA: unexpected %0h, expected none",
                        {frmErrA, parErrA, dataA});
            end else begin
               check("wordA", {frmErrA, parErrA, dataA}, qA.pop_front());
            end
         end
         if (validP && readyP) begin
            wordsP++;
            if (qP.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL wordP: unexpected %0h, expected none",
                        {frmErrP, parErrP, dataP});
            end else begin
               check("wordP", {frmErrP, parErrP, dataP}, qP.pop_front());
            end
         end
         if (overrunA) ovCntA++;
         if (breakA)   brkCntA++;
         if (eopA)     eopCntA++;
         if (overrunP) ovCntP++;
         if (breakP)   brkCntP++;
         if (eopP)     eopCntP++;
      end
   end

   task automatic lineA(input logic v, input int n);
      rxdA = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic lineP(input logic v, input int n);
      rxdP = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic sendA(input logic [7:0] d, input logic stopV = 1'b1,
                        input int spike = -1);
      lineA(1'b0, BITCLK);
      for (int i = 0; i < 8; i++) begin
         if (i == spike) begin
            lineA(d[i], 16);
            lineA(~d[i], 4);
            lineA(d[i], 12);
         end else begin
            lineA(d[i], BITCLK);
         end
      end
      lineA(stopV, BITCLK);
   endtask

   task automatic sendP(input logic [7:0] d, input logic parBit);
      lineP(1'b0, BITCLK);
      for (int i = 0; i < 8; i++) lineP(d[i], BITCLK);
      lineP(parBit, BITCLK);
      lineP(1'b1, BITCLK);
   endtask

   task automatic setReadyA(input logic v);
      @(posedge clk);
      #1 readyA = v;
      @(negedge clk);
   endtask

   initial begin
      int w0, e0, b0, o0;
      repeat (5) @(negedge clk);
      check("resetA", {dataA, parErrA, frmErrA, validA, overrunA,
                       breakA, idleA, eopA}, 0);
      check("resetP", {dataP, parErrP, frmErrP, validP, overrunP,
                       breakP, idleP, eopP}, 0);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check("noEopAfterReset", eopCntA, 0);
      check("idleAfterReset", idleA, 1);

      qA.push_back({2'b00, 8'hA5});
      qA.push_back({2'b00, 8'h3C});
      e0 = eopCntA;
      sendA(8'hA5);
      sendA(8'h3C);
      check("idleLowAfterBurst", idleA, 0);
      lineA(1'b1, 3 * BITCLK);
      check("eopAfterBurst", eopCntA - e0, 1);
      check("idleHighAfterGap", idleA, 1);
      check("wordsBurst", wordsA, 2);

      qP.push_back({2'b01, 8'h07});
      sendP(8'h07, 1'b0);
      qP.push_back({2'b00, 8'h07});
      sendP(8'h07, 1'b1);
      lineP(1'b1, 64);
      check("wordsParity", wordsP, 2);

      qA.push_back({2'b10, 8'h55});
      w0 = wordsA;
      sendA(8'h55, 1'b0);
      lineA(1'b1, 2 * BITCLK);
      check("wordsFrameErr", wordsA - w0, 1);

      b0 = brkCntA;
      w0 = wordsA;
      lineA(1'b0, 12 * BITCLK);
      lineA(1'b1, 2 * BITCLK);
      check("breakPulses", brkCntA - b0, 1);
      check("breakNoWord", wordsA - w0, 0);
      qA.push_back({2'b00, 8'h5A});
      sendA(8'h5A);
      lineA(1'b1, 64);
      check("wordAfterBreak", wordsA - w0, 1);

      w0 = wordsA;
      lineA(1'b0, 8);
      lineA(1'b1, 2 * BITCLK);
      check("glitchNoWord", wordsA - w0, 0);
      check("glitchValid", validA, 0);

      qA.push_back({2'b00, 8'h0F});
      sendA(8'h0F, 1'b1, 3);
      lineA(1'b1, 64);
      check("spikeWord", wordsA - w0, 1);

      w0 = wordsA;
      o0 = ovCntA;
      setReadyA(1'b0);
`ifdef UART_RX_FIFO_EN
      for (int i = 0; i < 17; i++) begin
         logic [7:0] v;
         v = 8'(i + 1);
         if (i < 16) qA.push_back({2'b00, v});
         sendA(v);
      end
      lineA(1'b1, 64);
      check("overrunCount", ovCntA - o0, 1);
      check("fifoValid", validA, 1);
      check("fifoHead", dataA, 8'h01);
      setReadyA(1'b1);
      repeat (40) @(negedge clk);
      check("fifoDelivered", wordsA - w0, 16);
`else
      qA.push_back({2'b00, 8'h11});
      sendA(8'h11);
      sendA(8'h22);
      lineA(1'b1, 64);
      check("overrunCount", ovCntA - o0, 1);
      check("holdValid", validA, 1);
      check("holdData", dataA, 8'h11);
      setReadyA(1'b1);
      repeat (10) @(negedge clk);
      check("holdDelivered", wordsA - w0, 1);
      check("holdEmptied", validA, 0);
`endif

      lineA(1'b0, BITCLK);
      lineA(1'b1, BITCLK);
      lineA(1'b1, BITCLK);
      lineA(1'b0, BITCLK);
      lineA(1'b0, 10);
      rst_n = 1'b0;
      rxdA = 1'b1;
      repeat (3) @(negedge clk);
      check("midResetA", {dataA, parErrA, frmErrA, validA, overrunA,
                          breakA, idleA, eopA}, 0);
      check("midResetP", {dataP, parErrP, frmErrP, validP, overrunP,
                          breakP, idleP, eopP}, 0);
      w0 = wordsA;
      e0 = eopCntA + brkCntA + ovCntA;
      rst_n = 1'b1;
      lineA(1'b1, 4 * BITCLK);
      check("noPulsesAfterReset", eopCntA + brkCntA + ovCntA - e0, 0);
      check("noWordAfterReset", wordsA - w0, 0);
      qA.push_back({2'b00, 8'h96});
      sendA(8'h96);
      lineA(1'b1, 64);
      check("wordAfterReset", wordsA - w0, 1);

      check("drainA", qA.size(), 0);
      check("drainP", qP.size(), 0);
      check("overrunP", ovCntP + brkCntP, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
